// File: rtl/cost_accumulator.sv
// Consumer of the serial (job, work, last) stream: addresses the cost memory, sums each
// permutation, and tracks the minimum total and its hit count. Optional macro: SEQ_CHECK_EN.
module cost_accumulator #(
    parameter int N_JOB  = 8,
    parameter int COST_W = 7,
    parameter int SUM_W  = 10,
    parameter int CNT_W  = 16,
    localparam int IDX_W = $clog2(N_JOB)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              valid,
    input  logic [IDX_W-1:0]  job,
    input  logic [IDX_W-1:0]  work,
    input  logic              last,
    output logic [IDX_W-1:0]  W,
    output logic [IDX_W-1:0]  J,
    input  logic [COST_W-1:0] Cost,
    output logic [SUM_W-1:0]  MinCost,
    output logic [CNT_W-1:0]  MatchCount,
    output logic              Done,
    output logic              Err,
    output logic [1:0]        state_dbg
);

    // Handshake: there is no ready. A pair is taken on every rising edge where valid=1 and
    // the FSM is in IDLE or ACCUM; in FIN/DONE valid pairs are dropped without effect.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FIN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_JOB - 1);

    state_t            state_q;
    state_t            state_d;
    logic              accept;

    logic              v1;
    logic [IDX_W-1:0]  widx1;
    logic              last1;
    logic [SUM_W-1:0]  acc;
    logic [SUM_W-1:0]  cost_ext;
    logic [SUM_W-1:0]  acc_next;

    logic              v2;
    logic              fin2;
    logic [SUM_W-1:0]  sum2;

    assign accept   = valid && (state_q == S_IDLE || state_q == S_ACCUM);
    assign cost_ext = {{(SUM_W - COST_W){1'b0}}, Cost};
    // A new permutation restarts the sum from the first returned cost.
    assign acc_next = (widx1 == '0) ? cost_ext : acc + cost_ext;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (accept && last) begin
                    state_d = S_FIN;
                end else if (accept) begin
                    state_d = S_ACCUM;
                end
            end
            S_FIN: begin
                if (fin2) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    assign Done      = (state_q == S_DONE);
    assign state_dbg = state_q;

    // Stage 0: cost-memory address; stage 1: accumulate; stage 2: compare.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            W          <= '0;
            J          <= '0;
            v1         <= 1'b0;
            widx1      <= '0;
            last1      <= 1'b0;
            acc        <= '0;
            v2         <= 1'b0;
            fin2       <= 1'b0;
            sum2       <= '0;
            MinCost    <= '1;
            MatchCount <= '0;
        end else begin
            v1 <= accept;
            if (accept) begin
                W     <= work;
                J     <= job;
                widx1 <= work;
                last1 <= last;
            end

            if (v1) begin
                acc <= acc_next;
            end
            v2   <= v1 && (widx1 == LAST_IDX);
            fin2 <= v1 && last1;
            if (v1 && (widx1 == LAST_IDX)) begin
                sum2 <= acc_next;
            end

            if (v2) begin
                if (sum2 < MinCost) begin
                    MinCost    <= sum2;
                    MatchCount <= CNT_W'(1);
                end else if (sum2 == MinCost && MatchCount != '1) begin
                    MatchCount <= MatchCount + CNT_W'(1);
                end
            end
        end
    end

`ifdef SEQ_CHECK_EN
    logic [IDX_W-1:0] exp_idx;
    logic             seq_bad;
    logic             err_q;

    // The mismatch is registered first, so Err rises one edge after the pair was taken.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            exp_idx <= '0;
            seq_bad <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            seq_bad <= accept && (work != exp_idx);
            if (accept) begin
                exp_idx <= (work == LAST_IDX) ? '0 : exp_idx + IDX_W'(1);
            end
            if (seq_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_cost_accumulator.sv
// Directed bench for cost_accumulator: table of permutation scenarios plus hand-written
// sequences for reset, gaps, post-Done input, protocol violation and sequence checking.
module tb_cost_accumulator;

    logic       CLK;
    logic       RST;
    logic       valid;
    logic [2:0] job;
    logic [2:0] work;
    logic       last;
    logic [2:0] W;
    logic [2:0] J;
    logic [6:0] Cost;
    logic [9:0] MinCost;
    logic [15:0] MatchCount;
    logic       Done;
    logic       Err;
    logic [1:0] state_dbg;

    logic [6:0] cost_mem [64];
    logic [5:0] exp_q [$];

    int checks;
    int errors;

    cost_accumulator dut (
        .CLK       (CLK),
        .RST       (RST),
        .valid     (valid),
        .job       (job),
        .work      (work),
        .last      (last),
        .W         (W),
        .J         (J),
        .Cost      (Cost),
        .MinCost   (MinCost),
        .MatchCount(MatchCount),
        .Done      (Done),
        .Err       (Err),
        .state_dbg (state_dbg)
    );

    assign Cost = cost_mem[{W, J}];

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        RST   = 1'b0;
        valid = 1'b0;
        job   = '0;
        work  = '0;
        last  = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        exp_q.delete();
    endtask

    // Every entry off the chosen diagonals is 127 so a wrong address shows in the sum.
    task automatic clear_mem();
        for (int i = 0; i < 64; i++) cost_mem[i] = 7'd127;
    endtask

    // Permutation with shift k uses job=(work+k)%8; workers 1..7 cost 3, worker 0 the rest.
    task automatic set_diag(input int k, input int total);
        for (int w = 0; w < 8; w++) begin
            cost_mem[w * 8 + ((w + k) % 8)] = (w == 0) ? 7'(total - 21) : 7'd3;
        end
    endtask

    // driver: one pair occupies one clock; returns at the negedge after it was sampled
    task automatic send(input int j, input int w, input bit l);
        valid = 1'b1;
        job   = 3'(j);
        work  = 3'(w);
        last  = l;
        exp_q.push_back({3'(j), 3'(w)});
        @(negedge CLK);
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic check_wj(input string name);
        logic [5:0] e;
        e = exp_q.pop_front();
        check({name, "_W"}, int'(W), int'(e[2:0]));
        check({name, "_J"}, int'(J), int'(e[5:3]));
    endtask

    // bounded wait for Done; returns the number of negedges it took, 99 if it never came
    task automatic wait_done(output int n);
        n = 99;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            if (Done) begin
                n = k;
                break;
            end
        end
    endtask

    typedef struct packed {
        int n_perm;
        int t0;
        int t1;
        int t2;
        int t3;
        int gap_after;
        int exp_min;
        int exp_cnt;
        int exp_cycles;
    } vec_t;

    function automatic int total_of(input vec_t v, input int p);
        case (p)
            0:       return v.t0;
            1:       return v.t1;
            2:       return v.t2;
            default: return v.t3;
        endcase
    endfunction

    vec_t vecs [4];

    initial begin
        int cyc;
        int n;
        checks = 0;
        errors = 0;

        vecs[0] = '{n_perm: 1, t0: 40, t1: 0,  t2: 0,  t3: 0,  gap_after: -1,
                    exp_min: 40, exp_cnt: 1, exp_cycles: 10};
        vecs[1] = '{n_perm: 1, t0: 40, t1: 0,  t2: 0,  t3: 0,  gap_after: 3,
                    exp_min: 40, exp_cnt: 1, exp_cycles: 13};
        vecs[2] = '{n_perm: 3, t0: 50, t1: 40, t2: 40, t3: 0,  gap_after: -1,
                    exp_min: 40, exp_cnt: 2, exp_cycles: 26};
        vecs[3] = '{n_perm: 4, t0: 60, t1: 30, t2: 30, t3: 30, gap_after: -1,
                    exp_min: 30, exp_cnt: 3, exp_cycles: 34};

        clear_mem();
        @(negedge CLK);
        do_reset();
        check("rst_min",   int'(MinCost), 1023);
        check("rst_cnt",   int'(MatchCount), 0);
        check("rst_done",  int'(Done), 0);
        check("rst_err",   int'(Err), 0);
        check("rst_W",     int'(W), 0);
        check("rst_J",     int'(J), 0);
        check("rst_state", int'(state_dbg), 0);

        // uniform memory of 5s, identity permutation
        for (int i = 0; i < 64; i++) cost_mem[i] = 7'd5;
        for (int w = 0; w < 8; w++) begin
            send(w, w, w == 7);
            check_wj("uni");
        end
        wait_done(n);
        check("uni_lat", n, 2);
        check("uni_min", int'(MinCost), 40);
        check("uni_cnt", int'(MatchCount), 1);

        // pairs after Done are dropped
        send(5, 2, 1'b0);
        exp_q.delete();
        send(1, 4, 1'b1);
        exp_q.delete();
        idle(2);
        check("post_W",     int'(W), 7);
        check("post_J",     int'(J), 7);
        check("post_min",   int'(MinCost), 40);
        check("post_cnt",   int'(MatchCount), 1);
        check("post_done",  int'(Done), 1);
        check("post_state", int'(state_dbg), 3);

        // table-driven permutation scenarios
        for (int v = 0; v < 4; v++) begin
            do_reset();
            clear_mem();
            for (int p = 0; p < vecs[v].n_perm; p++) set_diag(p, total_of(vecs[v], p));
            cyc = 0;
            for (int p = 0; p < vecs[v].n_perm; p++) begin
                for (int w = 0; w < 8; w++) begin
                    send((w + p) % 8, w, (p == vecs[v].n_perm - 1) && (w == 7));
                    check_wj($sformatf("v%0d", v));
                    cyc++;
                    if (w == vecs[v].gap_after) begin
                        idle(3);
                        cyc += 3;
                    end
                end
            end
            wait_done(n);
            check($sformatf("v%0d_lat", v), n, 2);
            check($sformatf("v%0d_cycles", v), cyc + n, vecs[v].exp_cycles);
            check($sformatf("v%0d_min", v), int'(MinCost), vecs[v].exp_min);
            check($sformatf("v%0d_cnt", v), int'(MatchCount), vecs[v].exp_cnt);
        end

        // reset mid-operation, with valid high while RST is low
        do_reset();
        clear_mem();
        set_diag(0, 50);
        set_diag(1, 30);
        set_diag(2, 40);
        for (int w = 0; w < 8; w++) send(w, w, 1'b0);
        for (int w = 0; w < 6; w++) send((w + 1) % 8, w, 1'b0);
        RST   = 1'b0;
        valid = 1'b1;
        job   = 3'd6;
        work  = 3'd6;
        repeat (2) @(negedge CLK);
        RST   = 1'b1;
        valid = 1'b0;
        exp_q.delete();
        check("mid_rst_min", int'(MinCost), 1023);
        check("mid_rst_W",   int'(W), 0);
        check("mid_rst_J",   int'(J), 0);
        for (int w = 0; w < 8; w++) send((w + 2) % 8, w, w == 7);
        exp_q.delete();
        wait_done(n);
        check("mid_lat", n, 2);
        check("mid_min", int'(MinCost), 40);
        check("mid_cnt", int'(MatchCount), 1);

        // last on a pair with work!=7: no comparison, Done still follows
        do_reset();
        clear_mem();
        set_diag(0, 40);
        for (int w = 0; w < 4; w++) send(w, w, w == 3);
        exp_q.delete();
        wait_done(n);
        check("viol_lat", n, 2);
        check("viol_min", int'(MinCost), 1023);
        check("viol_cnt", int'(MatchCount), 0);

        // work sequence 0,1,3
        do_reset();
        send(0, 0, 1'b0);
        send(1, 1, 1'b0);
        check("seq_ok_err", int'(Err), 0);
        send(3, 3, 1'b0);
        exp_q.delete();
        check("seq_t0_err", int'(Err), 0);
        idle(1);
`ifdef SEQ_CHECK_EN
        check("seq_t1_err", int'(Err), 1);
        idle(3);
        check("seq_sticky_err", int'(Err), 1);
`else
        check("seq_t1_err", int'(Err), 0);
        idle(3);
        check("seq_sticky_err", int'(Err), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
